// File: rtl/time_display.sv
// Remaining-time display: converts TIME_LIMIT - timeElapsed to BCD with a
// sequential shift-add-3 engine and drives three blanked, blinking 7-segment digits.
module time_display #(
    parameter int TIME_LIMIT    = 100,
    parameter int LOW_THRESHOLD = 10,
    parameter int BLINK_DIV     = 12_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] timeElapsed,
    input  logic       noMoreTime,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       lowTime,
    output logic       busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    localparam logic [6:0] LIMIT        = 7'(TIME_LIMIT);
    localparam logic [7:0] LOW_LIMIT    = 8'(LOW_THRESHOLD);
    localparam int         BW           = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    logic [1:0]    state;
    logic [2:0]    shift_count;
    logic [18:0]   shift_reg;     // {hundreds, tens, ones, binary}
    logic [6:0]    last_value;
    logic          pending;
    logic [3:0]    hundreds;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [BW-1:0] blink_count;
    logic          blink_phase;

    logic [6:0]    remaining;
    logic [18:0]   adjusted;
    logic [7:0]    two_digit;
    logic          low_next;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // NOTE: every always_comb output gets a full assignment on every path, so no latch is inferred.
    always_comb begin
        remaining = (timeElapsed >= LIMIT) ? 7'd0 : LIMIT - timeElapsed;
        adjusted  = {add3(shift_reg[18:15]), add3(shift_reg[14:11]),
                     add3(shift_reg[10:7]), shift_reg[6:0]};
        two_digit = {4'd0, tens} * 8'd10 + {4'd0, ones};
        low_next  = !noMoreTime && (hundreds == 4'd0) &&
                    (two_digit != 8'd0) && (two_digit <= LOW_LIMIT);
    end

    assign busy = (state != IDLE);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            shift_count <= 3'd0;
            shift_reg   <= 19'd0;
            last_value  <= 7'd0;
            pending     <= 1'b1;
            hundreds    <= 4'd0;
            tens        <= 4'd0;
            ones        <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (timeElapsed != last_value || pending) begin
                        shift_reg   <= {12'd0, remaining};
                        last_value  <= timeElapsed;
                        pending     <= 1'b0;
                        shift_count <= 3'd0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg   <= {adjusted[17:0], 1'b0};
                    shift_count <= shift_count + 3'd1;
                    if (shift_count == 3'd6)
                        state <= UPDATE;
                end
                UPDATE: begin
                    hundreds <= shift_reg[18:15];
                    tens     <= shift_reg[14:11];
                    ones     <= shift_reg[10:7];
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_count <= '0;
            blink_phase <= 1'b0;
        end else if (blink_count == '0) begin
            blink_count <= BLINK_RELOAD;
            blink_phase <= ~blink_phase;
        end else begin
            blink_count <= blink_count - 1'b1;
        end
    end

    // Time-up overrides everything; otherwise the low-time blink blanks all digits.
    always_ff @(posedge clock) begin
        if (reset) begin
            HEX2    <= SEG_BLANK;
            HEX1    <= SEG_BLANK;
            HEX0    <= SEG_BLANK;
            lowTime <= 1'b0;
        end else if (noMoreTime) begin
            HEX2    <= SEG_BLANK;
            HEX1    <= SEG_BLANK;
            HEX0    <= SEG_ZERO;
            lowTime <= 1'b0;
        end else begin
            lowTime <= low_next;
            if (low_next && blink_phase) begin
                HEX2 <= SEG_BLANK;
                HEX1 <= SEG_BLANK;
                HEX0 <= SEG_BLANK;
            end else begin
                HEX2 <= (hundreds == 4'd0) ? SEG_BLANK : seg(hundreds);
                HEX1 <= (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg(tens);
                HEX0 <= seg(ones);
            end
        end
    end

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display: reset, latency, blink, time-up, back-to-back
// changes, mid-conversion reset and a full input sweep.
module tb_time_display;

    localparam int TIME_LIMIT    = 100;
    localparam int LOW_THRESHOLD = 10;
    localparam int BLINK_DIV     = 4;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] timeElapsed = 7'd0;
    logic       noMoreTime = 1'b0;
    logic [6:0] HEX2;
    logic [6:0] HEX1;
    logic [6:0] HEX0;
    logic       lowTime;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    time_display #(
        .TIME_LIMIT   (TIME_LIMIT),
        .LOW_THRESHOLD(LOW_THRESHOLD),
        .BLINK_DIV    (BLINK_DIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .timeElapsed(timeElapsed),
        .noMoreTime (noMoreTime),
        .HEX2       (HEX2),
        .HEX1       (HEX1),
        .HEX0       (HEX0),
        .lowTime    (lowTime),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    task automatic ref_display(input int te, output logic [6:0] e2, output logic [6:0] e1,
                               output logic [6:0] e0, output logic el);
        int rem;
        int h;
        int t;
        int o;
        rem = (te >= TIME_LIMIT) ? 0 : TIME_LIMIT - te;
        h = rem / 100;
        t = (rem / 10) % 10;
        o = rem % 10;
        e2 = (h == 0) ? BLANK : seg_ref(h);
        e1 = (h == 0 && t == 0) ? BLANK : seg_ref(t);
        e0 = seg_ref(o);
        el = (rem >= 1 && rem <= LOW_THRESHOLD);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        tests_run++;
        if ({HEX2, HEX1, HEX0} !== {BLANK, BLANK, BLANK}) begin
            tests_failed++;
            $display("FAIL reset_hex: got %b_%b_%b expected all 1111111", HEX2, HEX1, HEX0);
        end
        tests_run++;
        if (lowTime !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got lowTime=%b busy=%b expected 0 0", lowTime, busy);
        end
    endtask

    task automatic test_reset_release_zero;
        timeElapsed = 7'd0;
        reset = 1'b0;
        tick(1);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pending_start_busy: got %b expected 1", busy);
        end
        tick(8);
        tests_run++;
        if ({HEX2, HEX1, HEX0} !== {BLANK, BLANK, 7'b1000000}) begin
            tests_failed++;
            $display("FAIL latency_before: got %b_%b_%b expected 1111111_1111111_1000000",
                     HEX2, HEX1, HEX0);
        end
        tick(1);
        tests_run++;
        if ({HEX2, HEX1, HEX0} !== {7'b1111001, 7'b1000000, 7'b1000000}) begin
            tests_failed++;
            $display("FAIL show_100: got %b_%b_%b expected 1111001_1000000_1000000",
                     HEX2, HEX1, HEX0);
        end
        tests_run++;
        if (lowTime !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL show_100_flags: got lowTime=%b busy=%b expected 0 0", lowTime, busy);
        end
    endtask

    task automatic test_low_time_blink;
        logic [6:0] seq [16];
        int bad_shape;
        int digit_count;
        int bad_period;
        int low_bad;
        bad_shape = 0;
        digit_count = 0;
        bad_period = 0;
        low_bad = 0;
        timeElapsed = 7'd95;
        tick(12);
        for (int i = 0; i < 16; i++) begin
            seq[i] = HEX0;
            if (HEX2 !== BLANK || HEX1 !== BLANK) bad_shape++;
            if (HEX0 === 7'b0010010) digit_count++;
            else if (HEX0 !== BLANK) bad_shape++;
            if (lowTime !== 1'b1) low_bad++;
            tick(1);
        end
        for (int i = 0; i < 12; i++)
            if (seq[i] === seq[i+4]) bad_period++;
        tests_run++;
        if (bad_shape != 0) begin
            tests_failed++;
            $display("FAIL blink_shape: got %0d bad samples expected 0", bad_shape);
        end
        tests_run++;
        if (digit_count != 8) begin
            tests_failed++;
            $display("FAIL blink_duty: got %0d lit samples of 16 expected 8", digit_count);
        end
        tests_run++;
        if (bad_period != 0) begin
            tests_failed++;
            $display("FAIL blink_period: got %0d non-toggling 4-cycle pairs expected 0", bad_period);
        end
        tests_run++;
        if (low_bad != 0) begin
            tests_failed++;
            $display("FAIL low_time_flag: got %0d cycles with lowTime!=1 expected 0", low_bad);
        end
    endtask

    task automatic test_time_up;
        int bad;
        noMoreTime = 1'b1;
        tick(1);
        tests_run++;
        if ({HEX2, HEX1, HEX0, lowTime} !== {BLANK, BLANK, 7'b1000000, 1'b0}) begin
            tests_failed++;
            $display("FAIL time_up_next_edge: got %b_%b_%b low=%b expected 1111111_1111111_1000000 low=0",
                     HEX2, HEX1, HEX0, lowTime);
        end
        for (int v = 100; v <= 101; v++) begin
            bad = 0;
            timeElapsed = 7'(v);
            for (int c = 0; c < 50; c++) begin
                tick(1);
                if ({HEX2, HEX1, HEX0, lowTime} !== {BLANK, BLANK, 7'b1000000, 1'b0}) bad++;
            end
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL time_up_steady_%0d: got %0d bad cycles expected 0", v, bad);
            end
        end
        noMoreTime = 1'b0;
    endtask

    task automatic test_back_to_back;
        int busy_high;
        int busy_rises;
        int first_89;
        logic saw_90;
        logic prev_busy;
        timeElapsed = 7'd50;
        tick(12);
        busy_high = 0;
        busy_rises = 0;
        first_89 = 0;
        saw_90 = 1'b0;
        prev_busy = busy;
        timeElapsed = 7'd10;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (c == 2) timeElapsed = 7'd11;
            if (busy === 1'b1) busy_high++;
            if (busy === 1'b1 && prev_busy === 1'b0) busy_rises++;
            prev_busy = busy;
            if ({HEX2, HEX1, HEX0} === {BLANK, 7'b0010000, 7'b1000000}) saw_90 = 1'b1;
            if (first_89 == 0 && {HEX2, HEX1, HEX0} === {BLANK, 7'b0000000, 7'b0010000})
                first_89 = c;
        end
        tests_run++;
        if (saw_90 !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first_value: got saw_90=%b expected 1", saw_90);
        end
        tests_run++;
        if (first_89 < 1 || first_89 > 19) begin
            tests_failed++;
            $display("FAIL b2b_second_value: got first 89 at cycle %0d expected 1..19", first_89);
        end
        tests_run++;
        if (busy_high != 16 || busy_rises != 2) begin
            tests_failed++;
            $display("FAIL b2b_busy: got %0d busy cycles %0d pulses expected 16 2",
                     busy_high, busy_rises);
        end
    endtask

    task automatic test_reset_mid_conversion;
        timeElapsed = 7'd37;
        tick(4);
        reset = 1'b1;
        tick(1);
        tests_run++;
        if ({HEX2, HEX1, HEX0} !== {BLANK, BLANK, BLANK} || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got %b_%b_%b busy=%b expected all 1111111 busy=0",
                     HEX2, HEX1, HEX0, busy);
        end
        reset = 1'b0;
        tick(10);
        tests_run++;
        if ({HEX2, HEX1, HEX0} !== {BLANK, 7'b0000010, 7'b0110000}) begin
            tests_failed++;
            $display("FAIL mid_reset_recover: got %b_%b_%b expected 1111111_0000010_0110000",
                     HEX2, HEX1, HEX0);
        end
    endtask

    task automatic test_sweep;
        logic [6:0] e2;
        logic [6:0] e1;
        logic [6:0] e0;
        logic el;
        logic ok;
        for (int v = 0; v < 128; v++) begin
            timeElapsed = 7'(v);
            tick(12);
            ref_display(v, e2, e1, e0, el);
            ok = ({HEX2, HEX1, HEX0} === {e2, e1, e0}) ||
                 (el && {HEX2, HEX1, HEX0} === {BLANK, BLANK, BLANK});
            tests_run++;
            if (!ok || lowTime !== el) begin
                tests_failed++;
                $display("FAIL sweep_%0d: got %b_%b_%b low=%b expected %b_%b_%b low=%b",
                         v, HEX2, HEX1, HEX0, lowTime, e2, e1, e0, el);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_reset_release_zero();
        test_low_time_blink();
        test_time_up();
        test_back_to_back();
        test_reset_mid_conversion();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
